// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state codes,
// RV32I opcodes, immediate-generator selects, ALU op codes, status bit map
// and the conditional-branch resolution rule.
package cu_pkg;

  // FSM state codes
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } instr_class_t;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Immediate generator selects
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  // ALU operations the control unit issues directly
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Status flag positions, {Z,N,C,V,rsvd} from MSB down
  localparam int ST_Z    = 4;
  localparam int ST_N    = 3;
  localparam int ST_C    = 2;
  localparam int ST_V    = 1;
  localparam int ST_RSVD = 0;

  // Supported branch funct3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Branch outcome from the flags of the rs1 - rs2 subtraction
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic n, input logic v);
    logic t;
    case (f3)
      F3_BEQ:  t = z;
      F3_BNE:  t = ~z;
      F3_BLT:  t = n ^ v;
      F3_BGE:  t = ~(n ^ v);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational instruction decoder: maps the latched instruction register
// to its class, branch-funct3 legality and the EXEC-phase ALU controls.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls,
  output logic         br_f3_ok,
  output logic         alusrc,
  output logic [3:0]   aluop,
  output logic [1:0]   immgen_ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       ir_unused;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7_b5 = ir[30];
  // Register specifiers and immediate bits are the datapath's business
  assign ir_unused = ^{ir[31], ir[29:15], ir[11:7]};

  // Branch conditions the ALU flags can resolve
  assign br_f3_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
                    (funct3 == F3_BLT) || (funct3 == F3_BGE);

  // Class and ALU control selection by major opcode
  always_comb begin
    cls         = CLS_ILLEGAL;
    alusrc      = 1'b0;
    aluop       = ALU_ADD;
    immgen_ctrl = IMM_NONE;
    case (opcode)
      OP_R: begin
        cls   = CLS_R;
        aluop = {funct7_b5, funct3};
      end
      OP_I: begin
        // funct7[5] only distinguishes srai from srli among immediates
        cls         = CLS_I;
        alusrc      = 1'b1;
        aluop       = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
        immgen_ctrl = IMM_I;
      end
      OP_LOAD: begin
        cls         = CLS_LOAD;
        alusrc      = 1'b1;
        immgen_ctrl = IMM_I;
      end
      OP_STORE: begin
        cls         = CLS_STORE;
        alusrc      = 1'b1;
        immgen_ctrl = IMM_S;
      end
      OP_BRANCH: begin
        cls         = CLS_BRANCH;
        aluop       = ALU_SUB;
        immgen_ctrl = IMM_B;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handles memory wait states with a timeout,
// resolves branches from ALU flags, traps on illegal encodings and counts
// retired instructions.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STATUS_W     = 5,
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     instr,
  input  logic                instr_valid,
  input  logic [STATUS_W-1:0] status,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pcsrc,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [1:0]          immgen_ctrl,
  output logic                mem_req,
  output logic                memrw,
  output logic                wb,
  output logic                regrw,
  output logic                busy,
  output logic                illegal,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    instret
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [2:0]        state_reg, state_next;
  logic [31:0]       ir_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              illegal_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  instret_reg;

  instr_class_t cls;
  logic         br_f3_ok;
  logic         dec_alusrc;
  logic [3:0]   dec_aluop;
  logic [1:0]   dec_imm;
  logic         taken;
  logic         wait_at_limit;
  logic         status_unused;

  // Only the 32-bit instruction word is decoded
  generate
    if (XLEN > 32) begin : g_wide_instr
      logic instr_hi_unused;
      assign instr_hi_unused = ^instr[XLEN-1:32];
    end
  endgenerate

  cu_decoder u_decoder (
    .ir          (ir_reg),
    .cls         (cls),
    .br_f3_ok    (br_f3_ok),
    .alusrc      (dec_alusrc),
    .aluop       (dec_aluop),
    .immgen_ctrl (dec_imm)
  );

  assign taken         = branch_taken(ir_reg[14:12], status[ST_Z], status[ST_N], status[ST_V]);
  assign status_unused = ^{status[ST_C], status[ST_RSVD]};
  assign wait_at_limit = (wait_reg == WAIT_W'(MEM_WAIT_MAX));

  // Next-state sequencing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = (cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_R, CLS_I:         state_next = S_WB;
          CLS_LOAD, CLS_STORE:  state_next = S_MEM;
          CLS_BRANCH:           state_next = br_f3_ok ? S_FETCH : S_TRAP;
          default:              state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        // A ready on the limit cycle still completes the access
        if (mem_ready)          state_next = (cls == CLS_LOAD) ? S_WB : S_FETCH;
        else if (wait_at_limit) state_next = S_TRAP;
      end
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore-style datapath controls; branch pcsrc and MEM exit follow live inputs
  always_comb begin
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    aluop       = '0;
    immgen_ctrl = IMM_NONE;
    mem_req     = 1'b0;
    memrw       = 1'b0;
    wb          = 1'b0;
    regrw       = 1'b0;
    case (state_reg)
      S_FETCH: ir_load = instr_valid & ~rst;
      S_EXEC: begin
        alusrc      = dec_alusrc;
        aluop       = ALUOP_W'(dec_aluop);
        immgen_ctrl = dec_imm;
        if (cls == CLS_BRANCH && br_f3_ok) begin
          pc_write = 1'b1;
          pcsrc    = taken;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        memrw    = (cls == CLS_STORE);
        pc_write = (cls == CLS_STORE) && mem_ready;
      end
      S_WB: begin
        regrw    = 1'b1;
        wb       = (cls == CLS_LOAD);
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_reg != S_FETCH);
  assign illegal     = illegal_reg;
  assign mem_timeout = timeout_reg;
  assign instret     = instret_reg;

  // State register and instruction latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && instr_valid) ir_reg <= instr[31:0];
    end
  end

  // Memory wait counter: cleared on MEM entry, counts cycles without ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_reg <= '0;
    end else if (state_next == S_MEM && state_reg != S_MEM) begin
      wait_reg <= '0;
    end else if (state_reg == S_MEM && state_next == S_MEM) begin
      wait_reg <= wait_reg + 1'b1;
    end
  end

  // Sticky trap causes, recorded on the transition into TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else if (state_next == S_TRAP && state_reg != S_TRAP) begin
      if (state_reg == S_MEM) timeout_reg <= 1'b1;
      else                    illegal_reg <= 1'b1;
    end
  end

  // Retired-instruction counter, one count per PC update, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (pc_write) begin
      instret_reg <= instret_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus
// randomized instruction streams checked cycle by cycle against an
// instruction-level reference model of the control sequencing.
module tb_multicycle_control_unit;

  localparam int XLEN         = 32;
  localparam int STATUS_W     = 5;
  localparam int ALUOP_W      = 4;
  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = 32;

  // Output vector layout: {ir_load,pc_write,pcsrc,alusrc,aluop[3:0],immgen[1:0],mem_req,memrw,wb,regrw,busy}
  localparam logic [14:0] M_ALL    = 15'h7FFF;
  localparam logic [14:0] M_STROBE = 15'h6013;  // ir_load, pc_write, mem_req, regrw, busy
  localparam logic [14:0] M_PCS    = 15'h1000;
  localparam logic [14:0] M_ALU    = 15'h0FE0;
  localparam logic [14:0] M_MRW    = 15'h0008;
  localparam logic [14:0] M_WB     = 15'h0004;

  logic                clk = 1'b0;
  logic                rst;
  logic [XLEN-1:0]     instr;
  logic                instr_valid;
  logic [STATUS_W-1:0] status;
  logic                mem_ready;
  logic                ir_load, pc_write, pcsrc, alusrc;
  logic [ALUOP_W-1:0]  aluop;
  logic [1:0]          immgen_ctrl;
  logic                mem_req, memrw, wb, regrw, busy, illegal, mem_timeout;
  logic [CNT_W-1:0]    instret;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .XLEN(XLEN), .STATUS_W(STATUS_W), .ALUOP_W(ALUOP_W),
    .MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .status(status), .mem_ready(mem_ready), .ir_load(ir_load),
    .pc_write(pc_write), .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop),
    .immgen_ctrl(immgen_ctrl), .mem_req(mem_req), .memrw(memrw), .wb(wb),
    .regrw(regrw), .busy(busy), .illegal(illegal), .mem_timeout(mem_timeout),
    .instret(instret)
  );

  function automatic logic [14:0] obs();
    return {ir_load, pc_write, pcsrc, alusrc, aluop, immgen_ctrl, mem_req, memrw, wb, regrw, busy};
  endfunction

  function automatic logic [14:0] mk(input bit irl, input bit pcw, input bit pcs, input bit alus,
                                     input logic [3:0] aop, input logic [1:0] imm, input bit mreq,
                                     input bit mrw, input bit wbv, input bit rrw, input bit bsy);
    return {irl, pcw, pcs, alus, aop, imm, mreq, mrw, wbv, rrw, bsy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; instr = '0; status = '0;
    step(); step();
    rst = 1'b0;
    exp_instret = '0;
  endtask

  // Runs one instruction from FETCH, checking every cycle against the model.
  // waits = number of mem_ready-low MEM cycles before ready (> MEM_WAIT_MAX means never).
  task automatic run_instr(input logic [31:0] ins, input logic [4:0] st, input int waits,
                           output bit trapped);
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          is_r, is_i, is_ld, is_st, is_br, br_ok, tk, rdy, exp_alus;
    logic [3:0]  exp_aop;
    logic [1:0]  exp_imm;
    logic [14:0] e, m, o;
    op = ins[6:0]; f3 = ins[14:12];
    is_r = (op == 7'h33); is_i = (op == 7'h13); is_ld = (op == 7'h03);
    is_st = (op == 7'h23); is_br = (op == 7'h63);
    br_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
    case (f3)
      3'd0:    tk = st[4];
      3'd1:    tk = !st[4];
      3'd4:    tk = st[3] ^ st[1];
      3'd5:    tk = !(st[3] ^ st[1]);
      default: tk = 1'b0;
    endcase
    if (is_r)               begin exp_alus = 0; exp_aop = {ins[30], f3}; exp_imm = 2'b11; end
    else if (is_i)          begin exp_alus = 1; exp_aop = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; exp_imm = 2'b00; end
    else if (is_ld || is_st) begin exp_alus = 1; exp_aop = 4'b0000; exp_imm = is_ld ? 2'b00 : 2'b01; end
    else                    begin exp_alus = 0; exp_aop = 4'b1000; exp_imm = 2'b10; end
    trapped = 0;

    // FETCH
    instr = ins; instr_valid = 1'b1; status = 5'($urandom); mem_ready = 1'($urandom);
    #4;
    o = obs(); e = mk(1,0,0,0,4'b0,2'b11,0,0,0,0,0); m = M_STROBE;
    n_checks++;
    if (((o ^ e) & m) !== 15'h0) begin n_fail++; $display("FAIL fetch %08h: outputs=%h expected=%h mask=%h", ins, o, e, m); end
    step();

    // DECODE: instr/status must be ignored here
    instr = $urandom; instr_valid = 1'($urandom); status = 5'($urandom);
    #4;
    o = obs(); e = mk(0,0,0,0,4'b0,2'b11,0,0,0,0,1); m = M_STROBE;
    n_checks++;
    if (((o ^ e) & m) !== 15'h0) begin n_fail++; $display("FAIL decode %08h: outputs=%h expected=%h mask=%h", ins, o, e, m); end
    step();

    if (!(is_r || is_i || is_ld || is_st || is_br)) begin
      #4;
      o = obs(); e = mk(0,0,0,0,4'b0,2'b11,0,0,0,0,1); m = M_STROBE;
      n_checks++;
      if (((o ^ e) & m) !== 15'h0 || illegal !== 1'b1 || mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL illegal_trap %08h: outputs=%h illegal=%b timeout=%b expected=%h illegal=1 timeout=0", ins, o, illegal, mem_timeout, e);
      end
      trapped = 1;
      $display("txn %08h trapped at decode", ins);
      return;
    end

    // EXEC
    status = st;
    #4;
    o = obs();
    e = mk(0, is_br && br_ok, is_br && br_ok && tk, exp_alus, exp_aop, exp_imm, 0,0,0,0,1);
    m = M_STROBE | ((is_br && !br_ok) ? 15'h0 : M_ALU) | ((is_br && br_ok) ? M_PCS : 15'h0);
    n_checks++;
    if (((o ^ e) & m) !== 15'h0) begin n_fail++; $display("FAIL exec %08h st=%b: outputs=%h expected=%h mask=%h", ins, st, o, e, m); end
    step();
    status = 5'($urandom);

    if (is_br) begin
      #4;
      if (br_ok) begin
        exp_instret++;
        n_checks++;
        if (instret !== exp_instret || busy !== 1'b0) begin
          n_fail++; $display("FAIL branch_retire %08h: instret=%0d busy=%b expected instret=%0d busy=0", ins, instret, busy, exp_instret);
        end
      end else begin
        n_checks++;
        if (illegal !== 1'b1 || busy !== 1'b1 || pc_write !== 1'b0 || instret !== exp_instret) begin
          n_fail++; $display("FAIL branch_trap %08h: illegal=%b busy=%b pc_write=%b instret=%0d expected 1 1 0 %0d", ins, illegal, busy, pc_write, instret, exp_instret);
        end
        trapped = 1;
      end
      $display("txn %08h branch f3=%0d taken=%0b trapped=%0b", ins, f3, tk, trapped);
      return;
    end

    if (is_ld || is_st) begin
      for (int k = 0; k <= MEM_WAIT_MAX; k++) begin
        rdy = (k == waits);
        mem_ready = rdy; status = 5'($urandom); instr = $urandom;
        #4;
        o = obs(); e = mk(0, is_st && rdy, 0, 0, 4'b0, 2'b11, 1, is_st, 0, 0, 1);
        m = M_STROBE | M_MRW | ((is_st && rdy) ? M_PCS : 15'h0);
        n_checks++;
        if (((o ^ e) & m) !== 15'h0) begin n_fail++; $display("FAIL mem %08h cyc=%0d: outputs=%h expected=%h mask=%h", ins, k, o, e, m); end
        step();
        if (rdy) break;
        if (k == MEM_WAIT_MAX) begin
          mem_ready = 1'b0;
          #4;
          n_checks++;
          if (mem_timeout !== 1'b1 || illegal !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b0 || pc_write !== 1'b0 || regrw !== 1'b0) begin
            n_fail++; $display("FAIL mem_timeout %08h: timeout=%b illegal=%b busy=%b mem_req=%b pc_write=%b regrw=%b expected 1 0 1 0 0 0", ins, mem_timeout, illegal, busy, mem_req, pc_write, regrw);
          end
          trapped = 1;
          $display("txn %08h memory timeout", ins);
          return;
        end
      end
      mem_ready = 1'b0;
      if (is_st) begin
        exp_instret++;
        #4;
        n_checks++;
        if (instret !== exp_instret || busy !== 1'b0) begin
          n_fail++; $display("FAIL store_retire %08h: instret=%0d busy=%b expected instret=%0d busy=0", ins, instret, busy, exp_instret);
        end
        $display("txn %08h store waits=%0d instret=%0d", ins, waits, instret);
        return;
      end
    end

    // WB
    mem_ready = 1'($urandom);
    #4;
    o = obs(); e = mk(0,1,0,0,4'b0,2'b11,0,0,is_ld,1,1); m = M_STROBE | M_PCS | M_WB;
    n_checks++;
    if (((o ^ e) & m) !== 15'h0) begin n_fail++; $display("FAIL writeback %08h: outputs=%h expected=%h mask=%h", ins, o, e, m); end
    step();
    exp_instret++;
    n_checks++;
    if (instret !== exp_instret || busy !== 1'b0) begin
      n_fail++; $display("FAIL wb_retire %08h: instret=%0d busy=%b expected instret=%0d busy=0", ins, instret, busy, exp_instret);
    end
    $display("txn %08h reg-write load=%0b instret=%0d", ins, is_ld, instret);
  endtask

  task automatic test_reset();
    logic [14:0] o;
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b1; instr = '1; status = '1;
    step(); step();
    #4;
    o = obs();
    n_checks++;
    if (o !== mk(0,0,0,0,4'b0,2'b11,0,0,0,0,0) || illegal !== 1'b0 || mem_timeout !== 1'b0 || instret !== '0) begin
      n_fail++; $display("FAIL reset: outputs=%h illegal=%b timeout=%b instret=%0d expected outputs=%h 0 0 0", o, illegal, mem_timeout, instret, mk(0,0,0,0,4'b0,2'b11,0,0,0,0,0));
    end
    step();
    rst = 1'b0; exp_instret = '0;
    $display("txn reset");
  endtask

  task automatic test_alu_ops();
    bit tr;
    run_instr(32'h007302B3, 5'($urandom), 0, tr);   // add x5,x6,x7
    run_instr(32'h00A28393, 5'($urandom), 0, tr);   // addi x7,x5,10
    run_instr(32'h40D2D293, 5'($urandom), 0, tr);   // srai: funct7[5] reaches aluop
    run_instr(32'h40D2C293, 5'($urandom), 0, tr);   // xori-like: funct7[5] masked
    n_checks++;
    if (instret !== 32'd4 || tr !== 1'b0) begin n_fail++; $display("FAIL alu_count: instret=%0d trapped=%b expected 4 0", instret, tr); end
  endtask

  task automatic test_store_wait();
    bit tr;
    run_instr(32'h0063A023, 5'($urandom), 3, tr);   // sw x6,0(x7), 3 wait cycles
    run_instr(32'h0063A023, 5'($urandom), MEM_WAIT_MAX, tr);  // ready on the limit cycle
    n_checks++;
    if (tr !== 1'b0 || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL store_limit: trapped=%b timeout=%b expected 0 0", tr, mem_timeout); end
    run_instr(32'h0003AE03, 5'($urandom), 2, tr);   // lw with 2 waits
  endtask

  task automatic test_load_timeout();
    bit tr;
    run_instr(32'h0003AE03, 5'($urandom), MEM_WAIT_MAX + 1, tr);
    n_checks++;
    if (tr !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: trapped=%b expected 1", tr); end
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1; mem_ready = 1'($urandom); instr = 32'h007302B3; status = 5'($urandom);
      step(); #4;
      n_checks++;
      if (busy !== 1'b1 || mem_timeout !== 1'b1 || ir_load !== 1'b0 || pc_write !== 1'b0) begin
        n_fail++; $display("FAIL trap_hold: busy=%b timeout=%b ir_load=%b pc_write=%b expected 1 1 0 0", busy, mem_timeout, ir_load, pc_write);
      end
    end
    apply_reset();
    #4;
    n_checks++;
    if (busy !== 1'b0 || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: busy=%b timeout=%b expected 0 0", busy, mem_timeout); end
  endtask

  task automatic test_branch();
    bit tr;
    run_instr(32'h01C38F63, 5'b10000, 0, tr);   // beq, Z=1 -> taken
    run_instr(32'h01C38F63, 5'b00000, 0, tr);   // beq, Z=0 -> not taken
    run_instr(32'h01C39F63, 5'b10000, 0, tr);   // bne, Z=1 -> not taken
    run_instr(32'h01C39F63, 5'b00000, 0, tr);   // bne, Z=0 -> taken
    run_instr(32'h01C3CF63, 5'b01000, 0, tr);   // blt, N^V
    run_instr(32'h01C3DF63, 5'b01010, 0, tr);   // bge, !(N^V)
    run_instr(32'h01C3AF63, 5'b10000, 0, tr);   // funct3=010 -> trap
    n_checks++;
    if (tr !== 1'b1 || instret !== 32'd6) begin n_fail++; $display("FAIL branch_f3_trap: trapped=%b instret=%0d expected 1 6", tr, instret); end
    apply_reset();
  endtask

  task automatic test_illegal();
    bit tr;
    run_instr(32'h0000007F, 5'($urandom), 0, tr);
    step(); step();
    rst = 1'b1;                    // asynchronous: takes effect mid-cycle
    #3;
    n_checks++;
    if (illegal !== 1'b0 || busy !== 1'b0 || immgen_ctrl !== 2'b11) begin
      n_fail++; $display("FAIL illegal_rst: illegal=%b busy=%b immgen=%b expected 0 0 11", illegal, busy, immgen_ctrl);
    end
    step();
    rst = 1'b0; exp_instret = '0;
    run_instr(32'h007302B3, 5'($urandom), 0, tr);
  endtask

  task automatic test_abort();
    instr = 32'h007302B3; instr_valid = 1'b1; status = '0; mem_ready = 1'b0;
    step(); instr_valid = 1'b0;    // now DECODE
    step();                        // now EXEC
    rst = 1'b1;
    #3;
    n_checks++;
    if (busy !== 1'b0 || pc_write !== 1'b0 || regrw !== 1'b0) begin
      n_fail++; $display("FAIL abort_now: busy=%b pc_write=%b regrw=%b expected 0 0 0", busy, pc_write, regrw);
    end
    step(); rst = 1'b0; exp_instret = '0;
    for (int i = 0; i < 3; i++) begin
      step(); #4;
      n_checks++;
      if (busy !== 1'b0 || regrw !== 1'b0 || pc_write !== 1'b0 || instret !== '0) begin
        n_fail++; $display("FAIL abort_idle: busy=%b regrw=%b pc_write=%b instret=%0d expected 0 0 0 0", busy, regrw, pc_write, instret);
      end
    end
    $display("txn abort mid-instruction");
  endtask

  task automatic test_random();
    bit          tr;
    int          kind, waits;
    logic [31:0] ins;
    logic [6:0]  op;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 19);
      ins = $urandom;
      if      (kind < 4)  op = 7'h33;
      else if (kind < 8)  op = 7'h13;
      else if (kind < 11) op = 7'h03;
      else if (kind < 14) op = 7'h23;
      else if (kind < 18) op = 7'h63;
      else begin
        op = 7'($urandom);
        while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63) op = 7'($urandom);
      end
      ins[6:0] = op;
      if (op == 7'h63 && $urandom_range(0, 3) != 0) ins[14:12] = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(4, 5));
      case ($urandom_range(0, 9))
        0:       waits = MEM_WAIT_MAX;
        1:       waits = MEM_WAIT_MAX + 1;
        default: waits = $urandom_range(0, 4);
      endcase
      run_instr(ins, 5'($urandom), waits, tr);
      if (tr) apply_reset();
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; status = '0; mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_store_wait();
    test_load_timeout();
    test_branch();
    test_illegal();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
